// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int MEM_LAT_MAX = 4;
  localparam logic [1:0] REQ_FETCH = 2'd0;
  localparam logic [1:0] REQ_DATA = 2'd1;
  localparam logic [1:0] REQ_STACK = 2'd2;
  typedef enum logic [2:0] {IDLE = 3'd0, ACCESS = 3'd1, WAIT = 3'd2, RESP = 3'd3} state_t;
  function automatic logic [1:0] oh2id(input logic [2:0] oh);
    return oh[2] ? REQ_STACK : oh[1] ? REQ_DATA : REQ_FETCH;
  endfunction
  function automatic logic [1:0] next_ptr(input logic [1:0] id);
    return (id == REQ_STACK) ? REQ_FETCH : id + 2'd1;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side and memory-side signals of the arbiter
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [2:0] req, we, gnt, done, state;
  logic [ADDR_W-1:0] addr0, addr1, addr2, mem_addr;
  logic [DATA_W-1:0] wdata0, wdata1, wdata2, rdata, mem_wdata, mem_rdata;
  logic busy, mem_en, mem_we;
  modport slave (
    input req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
    output gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata, state
  );
  modport master (
    output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
    input gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata, state
  );
endinterface

// File: rtl/arb_pick.sv
// arb_pick: one-hot winner from req; rotating priority from ptr, or fixed
// stack > data > fetch when ARB_FIXED_PRIO_EN is defined
module arb_pick (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] win,
  output logic       any
);
  assign any = |req;
`ifdef ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign win = req[2] ? 3'b100 : req[1] ? 3'b010 : req[0] ? 3'b001 : 3'b000;
`else
  logic [2:0] rr, g;
  // rotate so the pointer's requester is bit 0, pick lowest, rotate back
  always_comb begin
    rr = (ptr == 2'd1) ? {req[0], req[2:1]} : (ptr == 2'd2) ? {req[1:0], req[2]} : req;
    g = rr[0] ? 3'b001 : rr[1] ? 3'b010 : rr[2] ? 3'b100 : 3'b000;
    win = (ptr == 2'd1) ? {g[1:0], g[2]} : (ptr == 2'd2) ? {g[0], g[2:1]} : g;
  end
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port among fetch, data and stack requesters
// ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MEM_LAT = 1
) (
  input logic CLK,
  input logic Reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(MEM_LAT_MAX + 1);
  state_t st;
  logic [2:0] win;
  logic any, we_l;
  logic [1:0] ptr, id;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] a_sel;
  logic [DATA_W-1:0] d_sel;
  arb_pick u_pick (.req(bus.req), .ptr(ptr), .win(win), .any(any));
  assign bus.state = st;
  always_comb begin
    id = oh2id(win);
    a_sel = (id == REQ_STACK) ? bus.addr2 : (id == REQ_DATA) ? bus.addr1 : bus.addr0;
    d_sel = (id == REQ_STACK) ? bus.wdata2 : (id == REQ_DATA) ? bus.wdata1 : bus.wdata0;
  end
`ifdef ARB_FIXED_PRIO_EN
  assign ptr = 2'd0;
`endif
  always_ff @(posedge CLK) begin
    if (Reset) begin
      st <= IDLE;
      bus.gnt <= '0;
      bus.done <= '0;
      bus.busy <= 1'b0;
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.rdata <= '0;
      we_l <= 1'b0;
      cnt <= '0;
`ifndef ARB_FIXED_PRIO_EN
      ptr <= REQ_FETCH;
`endif
    end else begin
      case (st)
        IDLE: if (any) begin
          st <= ACCESS;
          bus.gnt <= win;
          bus.busy <= 1'b1;
          bus.mem_en <= 1'b1;
          bus.mem_we <= |(bus.we & win);
          we_l <= |(bus.we & win);
          bus.mem_addr <= a_sel;
          bus.mem_wdata <= d_sel;
        end
        ACCESS: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          cnt <= CW'(MEM_LAT);
          st <= we_l ? RESP : WAIT;
          bus.done <= we_l ? bus.gnt : 3'b000;
        end
        WAIT: if (cnt == CW'(1)) begin
          bus.rdata <= bus.mem_rdata;
          bus.done <= bus.gnt;
          st <= RESP;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: begin
          st <= IDLE;
          bus.done <= '0;
          bus.gnt <= '0;
          bus.busy <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
          ptr <= next_ptr(oh2id(bus.gnt));
`endif
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter (MEM_LAT=1 and MEM_LAT=4)
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int fails = 0;
  logic [11:0] e;
  always #5 CLK = ~CLK;
  mem_port_arbiter_if b1 ();
  mem_port_arbiter_if b4 ();
  mem_port_arbiter #(.MEM_LAT(1)) dut1 (.CLK(CLK), .Reset(Reset), .bus(b1.slave));
  mem_port_arbiter #(.MEM_LAT(4)) dut4 (.CLK(CLK), .Reset(Reset), .bus(b4.slave));

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [11:0] v1();
    return {b1.state, b1.gnt, b1.done, b1.busy, b1.mem_en, b1.mem_we};
  endfunction
  function automatic logic [11:0] v4();
    return {b4.state, b4.gnt, b4.done, b4.busy, b4.mem_en, b4.mem_we};
  endfunction
  function automatic logic [11:0] ex(input logic [2:0] s, input logic [2:0] g, input logic [2:0] d,
                                     input logic b, input logic en, input logic w);
    return {s, g, d, b, en, w};
  endfunction

  task automatic test_reset;
    {b1.req, b1.we, b1.addr0, b1.addr1, b1.addr2} = '0;
    {b1.wdata0, b1.wdata1, b1.wdata2, b1.mem_rdata} = '0;
    {b4.req, b4.we, b4.addr0, b4.addr1, b4.addr2} = '0;
    {b4.wdata0, b4.wdata1, b4.wdata2, b4.mem_rdata} = '0;
    Reset = 1'b1;
    tick();
    tick();
    checks++;
    if (v1() !== 12'h000) begin fails++; $display("FAIL reset_ctl got %h want 000", v1()); end
    checks++;
    if ({b1.rdata, b1.mem_addr, b1.mem_wdata} !== 48'h0) begin
      fails++; $display("FAIL reset_data got %h want 0", {b1.rdata, b1.mem_addr, b1.mem_wdata});
    end
    Reset = 1'b0;
  endtask

  task automatic test_single_read;
    b1.mem_rdata = 16'h321D;
    b1.addr0 = 16'h0040;
    b1.req = 3'b001;
    tick();
    e = ex(3'd1, 3'b001, 3'b000, 1'b1, 1'b1, 1'b0);
    checks++;
    if (v1() !== e) begin fails++; $display("FAIL rd_c1 got %h want %h", v1(), e); end
    checks++;
    if (b1.mem_addr !== 16'h0040) begin fails++; $display("FAIL rd_addr got %h want 0040", b1.mem_addr); end
    tick();
    e = ex(3'd2, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0);
    checks++;
    if (v1() !== e) begin fails++; $display("FAIL rd_c2 got %h want %h", v1(), e); end
    tick();
    e = ex(3'd3, 3'b001, 3'b001, 1'b1, 1'b0, 1'b0);
    checks++;
    if (v1() !== e) begin fails++; $display("FAIL rd_c3 got %h want %h", v1(), e); end
    checks++;
    if (b1.rdata !== 16'h321D) begin fails++; $display("FAIL rd_data got %h want 321d", b1.rdata); end
    b1.req = 3'b000;
    tick();
    checks++;
    if (v1() !== 12'h000) begin fails++; $display("FAIL rd_c4 got %h want 000", v1()); end
  endtask

  task automatic test_single_write;
    b1.mem_rdata = 16'hBEEF;
    b1.addr2 = 16'hFFFE;
    b1.wdata2 = 16'h0005;
    b1.we = 3'b100;
    b1.req = 3'b100;
    tick();
    e = ex(3'd1, 3'b100, 3'b000, 1'b1, 1'b1, 1'b1);
    checks++;
    if (v1() !== e) begin fails++; $display("FAIL wr_c1 got %h want %h", v1(), e); end
    checks++;
    if ({b1.mem_addr, b1.mem_wdata} !== 32'hFFFE0005) begin
      fails++; $display("FAIL wr_bus got %h want fffe0005", {b1.mem_addr, b1.mem_wdata});
    end
    tick();
    e = ex(3'd3, 3'b100, 3'b100, 1'b1, 1'b0, 1'b0);
    checks++;
    if (v1() !== e) begin fails++; $display("FAIL wr_c2 got %h want %h", v1(), e); end
    checks++;
    if (b1.rdata !== 16'h321D) begin fails++; $display("FAIL wr_rdata got %h want 321d", b1.rdata); end
    b1.req = 3'b000;
    b1.we = 3'b000;
    tick();
    checks++;
    if (v1() !== 12'h000) begin fails++; $display("FAIL wr_c3 got %h want 000", v1()); end
  endtask

  task automatic test_contention;
    logic [2:0] order [4];
    int cyc = 0;
    int last = 0;
`ifdef ARB_FIXED_PRIO_EN
    order = '{3'b100, 3'b100, 3'b100, 3'b100};
`else
    order = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
    b1.mem_rdata = 16'h5A5A;
    b1.req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      do begin tick(); cyc++; n++; end while (b1.done === 3'b000 && n < 20);
      checks++;
      if (b1.done !== order[k]) begin fails++; $display("FAIL cont_done%0d got %b want %b", k, b1.done, order[k]); end
      checks++;
      if (cyc - last !== (k == 0 ? 3 : 4)) begin
        fails++; $display("FAIL cont_gap%0d got %0d want %0d", k, cyc - last, k == 0 ? 3 : 4);
      end
      last = cyc;
    end
    checks++;
    if (b1.rdata !== 16'h5A5A) begin fails++; $display("FAIL cont_rdata got %h want 5a5a", b1.rdata); end
    b1.req = 3'b000;
    tick();
    tick();
    checks++;
    if (v1() !== 12'h000) begin fails++; $display("FAIL cont_idle got %h want 000", v1()); end
  endtask

  task automatic test_reset_mid;
`ifdef ARB_FIXED_PRIO_EN
    logic [2:0] g0 = 3'b100, g1 = 3'b100;
`else
    logic [2:0] g0 = 3'b010, g1 = 3'b001;
`endif
    b1.mem_rdata = 16'h1234;
    b1.addr1 = 16'h0777;
    b1.req = 3'b111;
    tick();
    checks++;
    if (b1.gnt !== g0) begin fails++; $display("FAIL rm_gnt0 got %b want %b", b1.gnt, g0); end
    tick();
    checks++;
    if (b1.state !== 3'd2) begin fails++; $display("FAIL rm_wait got %0d want 2", b1.state); end
    Reset = 1'b1;
    tick();
    checks++;
    if (v1() !== 12'h000) begin fails++; $display("FAIL rm_r1 got %h want 000", v1()); end
    checks++;
    if ({b1.rdata, b1.mem_addr, b1.mem_wdata} !== 48'h0) begin
      fails++; $display("FAIL rm_data got %h want 0", {b1.rdata, b1.mem_addr, b1.mem_wdata});
    end
    tick();
    checks++;
    if (v1() !== 12'h000) begin fails++; $display("FAIL rm_r2 got %h want 000", v1()); end
    Reset = 1'b0;
    tick();
    e = ex(3'd1, g1, 3'b000, 1'b1, 1'b1, 1'b0);
    checks++;
    if (v1() !== e) begin fails++; $display("FAIL rm_regrant got %h want %h", v1(), e); end
    tick();
    tick();
    checks++;
    if (b1.done !== g1) begin fails++; $display("FAIL rm_done got %b want %b", b1.done, g1); end
    checks++;
    if (b1.rdata !== 16'h1234) begin fails++; $display("FAIL rm_rdata got %h want 1234", b1.rdata); end
    b1.req = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_latency;
    b4.addr0 = 16'h0123;
    b4.mem_rdata = 16'h1000;
    b4.req = 3'b001;
    tick();
    b4.mem_rdata = 16'h1001;
    e = ex(3'd1, 3'b001, 3'b000, 1'b1, 1'b1, 1'b0);
    checks++;
    if (v4() !== e) begin fails++; $display("FAIL lat_c1 got %h want %h", v4(), e); end
    for (int c = 2; c <= 5; c++) begin
      tick();
      b4.mem_rdata = 16'h1000 + 16'(c);
      if (c == 2) b4.req = 3'b000;
      e = ex(3'd2, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0);
      checks++;
      if (v4() !== e) begin fails++; $display("FAIL lat_c%0d got %h want %h", c, v4(), e); end
    end
    tick();
    e = ex(3'd3, 3'b001, 3'b001, 1'b1, 1'b0, 1'b0);
    checks++;
    if (v4() !== e) begin fails++; $display("FAIL lat_c6 got %h want %h", v4(), e); end
    checks++;
    if (b4.rdata !== 16'h1005) begin fails++; $display("FAIL lat_rdata got %h want 1005", b4.rdata); end
    tick();
    checks++;
    if ({v4(), b4.rdata} !== {12'h000, 16'h1005}) begin
      fails++; $display("FAIL lat_c7 got %h want 0001005", {v4(), b4.rdata});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_reset_mid();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the processor's single-ported main memory between the three multi-cycle requesters: instruction fetch, data load/store, and stack push/pop. The block sits between the Control-sequenced datapath and the memory macro. It arbitrates one transaction at a time, drives the memory port, waits out the read latency, and returns read data with a one-cycle completion pulse.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 1, memory read latency in cycles after the enable cycle; legal range 1..4
- CLK  in  1  clock; all logic on the rising edge
- Reset  in  1  synchronous, active-high reset
- req[2:0]  in  3  per-requester request; bit 0 = fetch, 1 = data, 2 = stack
- we[2:0]  in  3  per-requester write enable; 1 = write
- addr0/addr1/addr2  in  ADDR_W each  per-requester address
- wdata0/wdata1/wdata2  in  DATA_W each  per-requester write data
- gnt[2:0]  out  3  one-hot grant; held from ACCESS through RESP
- done[2:0]  out  3  one-hot, one-cycle completion pulse
- rdata  out  DATA_W  read data; valid while done is high, held until the next read completes
- busy  out  1  high in every state except IDLE
- mem_en, mem_we  out  1 each  memory enable and write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- state  out  3  current FSM state, exported for debug and benches

## Operation
- The FSM has four states: IDLE=0, ACCESS=1, WAIT=2, RESP=3.
- IDLE: if any req bit is set, pick a winner, register its ID/we/addr/wdata, set gnt, and go to ACCESS. Otherwise stay in IDLE.
- ACCESS: mem_en=1, mem_we=latched we, mem_addr and mem_wdata from the latched operands. A read goes to WAIT with the counter set to MEM_LAT. A write goes to RESP.
- WAIT: the counter decrements each cycle. On the cycle the counter equals 1, latch mem_rdata into rdata and go to RESP.
- RESP: done[winner]=1, then go to IDLE. gnt clears on the transition to IDLE.
- Default winner selection is round-robin. The search starts at the priority pointer; after each RESP the pointer becomes winner+1 mod 3. The pointer resets to 0 (fetch).
- A requester holds req, we, addr and wdata stable until its done pulse.
  - Operands are latched in IDLE, so changes after the grant are ignored.
  - If req drops mid-transaction, the transaction still completes and done still pulses.
- A requester that keeps req high after done is re-arbitrated normally. It does not get back-to-back priority under round-robin.
- Writes leave rdata unchanged.
- Reset, at any time including mid-transaction:
  - next state is IDLE, with no done pulse for the aborted access;
  - gnt, done, busy, mem_en, mem_we, mem_addr, mem_wdata, rdata and state all return to 0;
  - the pointer returns to 0.

## Timing
- All outputs are registered.
- Requests are sampled at the IDLE edge (cycle 0), and ACCESS is cycle 1.
- Read: WAIT occupies cycles 2..MEM_LAT+1, and done/rdata appear in cycle MEM_LAT+2.
- Write: the memory write happens in cycle 1, and done appears in cycle 2.
- RESP is always followed by one IDLE cycle. Back-to-back accesses therefore enable memory every MEM_LAT+3 cycles for reads and every 3 cycles for writes.
- Simultaneous requests: exactly one gnt bit is set, chosen by the policy below. The others wait with req held.

## Configuration
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority, stack > data > fetch. The pointer logic is compiled out, and the pointer reads as 0.
- Undefined: round-robin as described in Operation.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE/ACCESS/WAIT/RESP with the encodings above);
  - requester ID constants REQ_FETCH=0, REQ_DATA=1, REQ_STACK=2;
  - default ADDR_W/DATA_W;
  - the MEM_LAT maximum.
- Sub-module arb_pick, combinational: takes req[2:0] and a pointer, returns a one-hot winner and an any-request flag. It holds both the rotate-priority and the fixed-priority variants under the macro.

## Test plan
- Reset: hold Reset high for 2 cycles during a read's WAIT state → state=0, all outputs 0, no done pulse, and the next request is served from the pointer value 0.
- Single read, MEM_LAT=1: req=3'b001, addr0=16'h0040, memory returns 16'h321D → gnt=001 from cycle 1, mem_en=1 only in cycle 1, done=001 and rdata=16'h321D in cycle 3, state sequence 0,1,2,3,0.
- Single write: req=3'b100, we=3'b100, addr2=16'hFFFE, wdata2=16'h0005 → mem_we=1 with that address and data in cycle 1, done=100 in cycle 2, rdata unchanged.
- Round-robin contention: req=3'b111 held continuously, reads → grant order fetch, data, stack, fetch, with each done spaced MEM_LAT+3 cycles apart.
- Fixed priority (ARB_FIXED_PRIO_EN defined): req=3'b111 held → stack granted repeatedly, and fetch is never granted while stack requests.
- Latency sweep: MEM_LAT=4 read → done in cycle 6, with rdata equal to the mem_rdata sampled in cycle 5. Dropping req in cycle 2 still yields done in cycle 6.
